// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider / tick generator, synchronous to clkin.
// Each channel has a divisor and high time that only change at period boundaries, so no runt pulses.
module clk_div_bank #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CHW     = 2,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEF_DIV = 18
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   div_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  localparam int unsigned NSEL = 1 << CHW;
  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEF_DIV / 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Unimplemented channel selects read as never-pending, so they always accept.
  logic [NSEL-1:0] pend_ext;
  assign pend_ext  = NSEL'(pend);
  assign cfg_ready = !pend_ext[cfg_ch];

  logic [WIDTH-1:0] div_cl;
  logic [WIDTH-1:0] high_cl;

  // High time is clamped against the already-clamped divisor.
  always_comb begin
    div_cl = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;
    if (cfg_high == '0)
      high_cl = div_cl >> 1;
    else if (cfg_high >= div_cl)
      high_cl = div_cl - WIDTH'(1);
    else
      high_cl = cfg_high;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] sdiv_q, sdiv_d;
    logic [WIDTH-1:0] shigh_q, shigh_d;
    logic             pend_q, pend_d;
    logic             dout_q, dout_d;
    logic             tick_q, tick_d;
    logic             xfer;
    logic             wrap;

    assign xfer = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));
    assign wrap = (state_q != IDLE) && (cnt_q == div_q - WIDTH'(1));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      high_d  = high_q;
      sdiv_d  = sdiv_q;
      shigh_d = shigh_q;
      pend_d  = pend_q;

      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (ch_en[i]) state_d = RUN;
        end
        RUN: begin
          cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
          if (!ch_en[i]) state_d = DRAIN;
        end
        DRAIN: begin
          cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
          if (ch_en[i])  state_d = RUN;
          else if (wrap) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // Apply and transfer are mutually exclusive because cfg_ready is low while pending.
      if (wrap && pend_q) begin
        div_d  = sdiv_q;
        high_d = shigh_q;
        pend_d = 1'b0;
      end

      if (xfer) begin
        if (state_q == IDLE) begin
          div_d  = div_cl;
          high_d = high_cl;
        end else begin
          sdiv_d  = div_cl;
          shigh_d = high_cl;
          pend_d  = 1'b1;
        end
      end

      dout_d = (state_d != IDLE) && (cnt_d < high_d);
      tick_d = (state_d != IDLE) && (cnt_d == '0);
    end

    always_ff @(posedge clkin) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        div_q   <= RST_DIV;
        high_q  <= RST_HIGH;
        sdiv_q  <= RST_DIV;
        shigh_q <= RST_HIGH;
        pend_q  <= 1'b0;
        dout_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        high_q  <= high_d;
        sdiv_q  <= sdiv_d;
        shigh_q <= shigh_d;
        pend_q  <= pend_d;
        dout_q  <= dout_d;
        tick_q  <= tick_d;
      end
    end

    assign div_out[i] = dout_q;
    assign tick[i]    = tick_q;
    assign pend[i]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: per-edge expected waveforms are queued with the stimulus
// and compared one cycle-tagged entry at a time after each rising edge.
module tb_clk_div_bank;

  localparam int unsigned NCH     = 4;
  localparam int unsigned CHW     = 3;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEF_DIV = 18;

  logic             clkin = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch = '0;
  logic [WIDTH-1:0] cfg_div = '0;
  logic [WIDTH-1:0] cfg_high = '0;
  logic [NCH-1:0]   ch_en = '0;
  logic [NCH-1:0]   div_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pend;

  clk_div_bank #(
    .NCH(NCH), .CHW(CHW), .WIDTH(WIDTH), .DEF_DIV(DEF_DIV)
  ) dut (
    .clkin(clkin), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high),
    .ch_en(ch_en), .div_out(div_out), .tick(tick), .pend(pend)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int          cyc;
    int          ch;
    int          kind;   // 0 div_out[ch], 1 tick[ch], 2 whole pend vector
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void push_wave(int ch, int e, int ph, int hi, string tag);
    sb.push_back('{cyc: e, ch: ch, kind: 0, exp: 32'(ph < hi), tag: {tag, "_div"}});
    sb.push_back('{cyc: e, ch: ch, kind: 1, exp: 32'(ph == 0), tag: {tag, "_tick"}});
  endfunction

  function automatic void push_idle(int ch, int e, string tag);
    push_wave(ch, e, 1, 0, tag);
  endfunction

  function automatic void push_pend(int e, logic [31:0] v, string tag);
    sb.push_back('{cyc: e, ch: 0, kind: 2, exp: v, tag: tag});
  endfunction

  // After each rising edge, compare every entry due on this edge.
  always @(posedge clkin) begin : mon
    int          i;
    logic [31:0] act;
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          0:       act = 32'(div_out[sb[i].ch]);
          1:       act = 32'(tick[sb[i].ch]);
          default: act = 32'(pend);
        endcase
        chk(sb[i].tag, act, sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic nedge(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_en = '0;
    cfg_valid = 1'b0;
    nedge(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    int now;
    int w;
    int t;

    nedge(2);
    chk("rst_div_out", 32'(div_out), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_pend", 32'(pend), 32'(0));
    chk("rst_ready", 32'(cfg_ready), 32'(1));
    rst = 1'b0;
    nedge(1);

    // Defaults: 18-cycle period, 9 high, first tick one edge after enable
    ch_en[0] = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 40; k++) begin
      push_wave(0, base + k, k % 18, 9, "s1_ch0");
      push_idle(1, base + k, "s1_ch1");
    end
    nedge(41);

    // Reconfigure at cnt=7: old period completes, then 5-cycle periods 2 high
    while (((cyc - base) % 18) != 7) nedge(1);
    now = cyc;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd5; cfg_high = 8'd0;
    chk("s2_ready_free", 32'(cfg_ready), 32'(1));
    w = now + 11;
    for (int e = now + 1; e <= now + 30; e++) begin
      if (e < w) begin
        push_wave(0, e, (e - base) % 18, 9, "s2_old");
        push_pend(e, 32'(1), "s2_pend_set");
      end else begin
        push_wave(0, e, (e - w) % 5, 2, "s2_new");
        push_pend(e, 32'(0), "s2_pend_clr");
      end
    end
    nedge(1);
    cfg_valid = 1'b0;
    chk("s2_ready_busy", 32'(cfg_ready), 32'(0));
    nedge(30);

    // Drop enable at cnt=3: period completes, then parks low
    do_reset();
    ch_en[0] = 1'b1;
    base = cyc + 1;
    for (int e = base; e <= base + 22; e++) begin
      if (e - base < 18) push_wave(0, e, e - base, 9, "s3_drain");
      else               push_idle(0, e, "s3_park");
    end
    nedge(4);
    ch_en[0] = 1'b0;
    nedge(20);

    // Re-raise during DRAIN: waveform continues without phase change
    ch_en[0] = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 60; k++) push_wave(0, base + k, k % 18, 9, "s3_resume");
    nedge(20);
    ch_en[0] = 1'b0;
    nedge(5);
    ch_en[0] = 1'b1;
    nedge(35);

    // Clamp on IDLE channel: div 1 -> 2, high 7 -> 1, applied directly
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd1; cfg_high = 8'd7;
    chk("s4_ready", 32'(cfg_ready), 32'(1));
    nedge(1);
    cfg_valid = 1'b0;
    chk("s4_pend_idle", 32'(pend), 32'(0));
    ch_en[1] = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 12; k++) begin
      push_wave(1, base + k, k % 2, 1, "s4_ch1");
      push_pend(base + k, 32'(0), "s4_pend");
    end
    nedge(13);

    // Concurrent channels; out-of-range channel transfers leave everything alone
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd6; cfg_high = 8'd1;
    nedge(1);
    cfg_valid = 1'b0;
    ch_en = 4'b0101;
    base = cyc + 1;
    for (int k = 0; k < 48; k++) begin
      push_wave(0, base + k, k % 18, 9, "s5_ch0");
      push_wave(2, base + k, k % 6, 1, "s5_ch2");
      push_idle(1, base + k, "s5_ch1");
      push_pend(base + k, 32'(0), "s5_pend");
    end
    nedge(10);
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd3; cfg_high = 8'd1;
    chk("s5_ready_ch5", 32'(cfg_ready), 32'(1));
    nedge(1);
    cfg_ch = 3'd4;
    chk("s5_ready_ch4", 32'(cfg_ready), 32'(1));
    nedge(1);
    cfg_valid = 1'b0;
    cfg_ch = 3'd0;
    nedge(37);

    // Reset with a pending shadow: shadow discarded, default period returns
    do_reset();
    ch_en[3] = 1'b1;
    nedge(5);
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd4; cfg_high = 8'd0;
    chk("s6_ready_free", 32'(cfg_ready), 32'(1));
    nedge(1);
    cfg_valid = 1'b0;
    chk("s6_pend_set", 32'(pend), 32'(8));
    chk("s6_ready_busy", 32'(cfg_ready), 32'(0));
    nedge(2);
    rst = 1'b1;
    t = cyc;
    for (int c = 0; c < 4; c++) push_idle(c, t + 1, "s6_rst");
    push_pend(t + 1, 32'(0), "s6_rst_pend");
    base = t + 2;
    for (int k = 0; k < 40; k++) begin
      push_wave(3, base + k, k % 18, 9, "s6_ch3");
      push_pend(base + k, 32'(0), "s6_pend");
    end
    nedge(1);
    rst = 1'b0;
    nedge(41);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
